maxnet_feeder: RTL and testbench
================================

MAXNET_FEEDER -- requirements
Module: maxnet_feeder

Interface
REQ-001 Parameter DATA_W, default 32: width of one input word and of the result.
REQ-002 Parameter N, default 4: number of words per MaxNet job.
REQ-003 Parameter TIMEOUT_CYC, default 1023: maximum WAIT-state cycles before abort (used only with the watchdog compiled in).
REQ-004 Port clk  in  1: single clock; all logic on rising edge.
REQ-005 Port rst_n  in  1: reset, synchronous, active-low.
REQ-006 Port in_data  in  DATA_W: serial job word.
REQ-007 Port in_valid  in  1: in_data is valid.
REQ-008 Port in_ready  out  1: feeder accepts a word this cycle.
REQ-009 Port dp_a  out  N*DATA_W: job vector to the datapath; element 0 in the LSBs.
REQ-010 Port dp_load  out  1: one-cycle load strobe to the datapath.
REQ-011 Port dp_run  out  1: datapath iteration enable.
REQ-012 Port dp_finished  in  1: datapath reports one nonzero survivor.
REQ-013 Port dp_res  in  DATA_W: datapath winner value.
REQ-014 Port res  out  DATA_W: captured result.
REQ-015 Port res_valid  out  1: res is valid.
REQ-016 Port res_ready  in  1: consumer accepts res.
REQ-017 Port timeout  out  1: current result was produced by watchdog abort.
REQ-018 Port busy  out  1: high in every state except LOAD with word count 0.

Function
REQ-019 FSM states LOAD, START, WAIT, OUT; exactly one active per cycle.
REQ-020 LOAD: in_ready=1; each in_valid&in_ready beat writes in_data to element cnt, then cnt increments.
REQ-021 The first word received in a job is element 0; word k is element k.
REQ-022 The beat accepting word N-1 moves the FSM to START next cycle and clears cnt; in_ready=0 outside LOAD.
REQ-023 START lasts exactly one cycle with dp_load=1; dp_a is stable from START until the job leaves WAIT.
REQ-024 WAIT: dp_run=1; dp_finished is ignored in START and sampled only in WAIT.
REQ-025 WAIT with dp_finished=1: res<=dp_res, timeout<=0, move to OUT next cycle; latency dp_finished to res_valid is 1 cycle.
REQ-026 OUT: res_valid=1 and res is held until res_ready=1; that cycle returns to LOAD; res_valid drops next cycle.
REQ-027 res_valid and res_ready both high on the first OUT cycle: accept, return to LOAD.
REQ-028 in_valid during START, WAIT or OUT: no word is accepted and the element registers are unchanged.
REQ-029 dp_load and dp_run are never high in the same cycle.

Reset
REQ-030 rst_n=0 at a clock edge: FSM to LOAD, cnt=0, elements=0, res=0, res_valid=0, timeout=0, dp_load=0, dp_run=0, in_ready=1 from the first post-reset cycle.
REQ-031 Reset mid-job in any state discards the partial job; the next accepted word is element 0.

Configuration
REQ-032 Macro MAXNET_FEEDER_WATCHDOG_EN compiles in a WAIT cycle counter, cleared on WAIT entry.
REQ-033 With the macro, reaching TIMEOUT_CYC WAIT cycles without dp_finished moves to OUT with res=0 and timeout=1; dp_finished on that same cycle takes priority, giving the normal result with timeout=0.
REQ-034 Without the macro, timeout is tied to 0 and WAIT is unbounded.

Structure
REQ-035 Package maxnet_pkg holds the FSM state enum, DATA_W and N defaults, and the cnt width constant $clog2(N).
REQ-036 No sub-module; single flat module.

Verification
REQ-037 Feed 5,9,3,7 with back-to-back in_valid -> dp_a={7,3,9,5}, dp_load one cycle, dp_run next cycle; dp_finished with dp_res=9 -> res=9, res_valid one cycle later.
REQ-038 res_ready=0 for 10 cycles in OUT -> res stays 9 and in_ready stays 0; res_ready=1 -> LOAD next cycle.
REQ-039 Assert in_valid during WAIT with data 0xFFFF -> element registers are unchanged and no word is counted.
REQ-040 rst_n=0 after 2 of 4 words, then 4 words 1,2,3,4 -> dp_a={4,3,2,1}.
REQ-041 Watchdog on, TIMEOUT_CYC=8, no dp_finished -> after 8 WAIT cycles res=0, timeout=1, res_valid=1.
REQ-042 Watchdog on, dp_finished on the 8th WAIT cycle with dp_res=0x2A -> res=0x2A, timeout=0.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet job feeder: FSM state encoding, default
// sizes and the word-counter width helper.
package maxnet_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_DEF      = 4;
  localparam int CNT_W_DEF  = $clog2(N_DEF);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxnet_feeder.sv
// Serial-to-parallel job feeder for a MaxNet datapath with a result handshake.
// Optional WAIT watchdog compiled in with `define MAXNET_FEEDER_WATCHDOG_EN.
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int N           = N_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N*DATA_W-1:0] dp_a,
  output logic                dp_load,
  output logic                dp_run,
  input  logic                dp_finished,
  input  logic [DATA_W-1:0]   dp_res,
  output logic [DATA_W-1:0]   res,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                timeout,
  output logic                busy
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] LOAD  = 2'(ST_LOAD);
  localparam logic [1:0] START = 2'(ST_START);
  localparam logic [1:0] WAIT  = 2'(ST_WAIT);
  localparam logic [1:0] OUT   = 2'(ST_OUT);

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] elem_q [N];
  logic [DATA_W-1:0] res_q;
  logic              wd_expired;

  assign in_ready  = (state_q == LOAD);
  assign dp_load   = (state_q == START);
  assign dp_run    = (state_q == WAIT);
  assign res_valid = (state_q == OUT);
  assign res       = res_q;
  assign busy      = !((state_q == LOAD) && (cnt_q == '0));

  for (genvar k = 0; k < N; k++) begin : g_dp_a
    assign dp_a[k*DATA_W +: DATA_W] = elem_q[k];
  end

`ifdef MAXNET_FEEDER_WATCHDOG_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  assign wd_expired = (state_q == WAIT) && (wd_q == WD_LAST);
  assign timeout    = timeout_q;

  // WAIT-cycle counter: zeroed in START so each job gets the full budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        wd_q <= '0;
      end else if (state_q == WAIT) begin
        wd_q <= wd_q + 1'b1;
      end
      if (state_q == WAIT) begin
        if (dp_finished) begin
          timeout_q <= 1'b0;
        end else if (wd_expired) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign wd_expired         = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      res_q   <= '0;
      for (int k = 0; k < N; k++) begin
        elem_q[k] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            elem_q[cnt_q] <= in_data;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        START: state_q <= WAIT;
        // A finish on the expiry cycle wins over the abort.
        WAIT: begin
          if (dp_finished) begin
            res_q   <= dp_res;
            state_q <= OUT;
          end else if (wd_expired) begin
            res_q   <= '0;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Self-checking bench for maxnet_feeder: table vectors, reset corner cases,
// randomized jobs and watchdog sequences when MAXNET_FEEDER_WATCHDOG_EN is set.
module tb_maxnet_feeder;

  localparam int DATA_W      = 16;
  localparam int N           = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int AW          = N * DATA_W;

  typedef logic [N-1:0][DATA_W-1:0] words_t;

  typedef struct {
    words_t            w;
    logic [AW-1:0]     exp_a;
    int                gap;
    int                fin_dly;
    logic [DATA_W-1:0] dres;
    int                hold;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     dp_a;
  logic              dp_load;
  logic              dp_run;
  logic              dp_finished;
  logic [DATA_W-1:0] dp_res;
  logic [DATA_W-1:0] res;
  logic              res_valid;
  logic              res_ready;
  logic              timeout;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  maxnet_feeder #(
    .DATA_W      (DATA_W),
    .N           (N),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dp_a        (dp_a),
    .dp_load     (dp_load),
    .dp_run      (dp_run),
    .dp_finished (dp_finished),
    .dp_res      (dp_res),
    .res         (res),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", AW'(in_ready), 1);
    check("rst_busy", AW'(busy), 0);
    check("rst_dp_load", AW'(dp_load), 0);
    check("rst_dp_run", AW'(dp_run), 0);
    check("rst_res_valid", AW'(res_valid), 0);
    check("rst_res", AW'(res), 0);
    check("rst_timeout", AW'(timeout), 0);
    check("rst_dp_a", dp_a, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Back-to-back feed of one job; returns sitting in the START cycle.
  task automatic feed(input words_t w);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = w[k];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input words_t w, input logic [AW-1:0] exp_a, input int gap,
                         input int fin_dly, input logic [DATA_W-1:0] dres, input int hold);
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = w[k];
      check("load_in_ready", AW'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    // START: a finish report here must be ignored.
    dp_finished = 1'b1;
    dp_res      = '1;
    check("start_dp_load", AW'(dp_load), 1);
    check("start_dp_run", AW'(dp_run), 0);
    check("start_in_ready", AW'(in_ready), 0);
    check("start_dp_a", dp_a, exp_a);
    check("start_busy", AW'(busy), 1);
    step();
    dp_finished = 1'b0;
    for (int i = 0; i < fin_dly; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      check("wait_dp_run", AW'(dp_run), 1);
      check("wait_dp_load", AW'(dp_load), 0);
      check("wait_res_valid", AW'(res_valid), 0);
      check("wait_dp_a", dp_a, exp_a);
      step();
    end
    in_valid    = 1'b0;
    dp_finished = 1'b1;
    dp_res      = dres;
    check("wait_dp_run_fin", AW'(dp_run), 1);
    step();
    dp_finished = 1'b0;
    check("out_res_valid", AW'(res_valid), 1);
    check("out_res", AW'(res), AW'(dres));
    check("out_timeout", AW'(timeout), 0);
    check("out_dp_run", AW'(dp_run), 0);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hFFFF;
      check("hold_res_valid", AW'(res_valid), 1);
      check("hold_res", AW'(res), AW'(dres));
      check("hold_in_ready", AW'(in_ready), 0);
      step();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("ret_res_valid", AW'(res_valid), 0);
    check("ret_in_ready", AW'(in_ready), 1);
    check("ret_busy", AW'(busy), 0);
    check("ret_dp_a", dp_a, exp_a);
  endtask

  vec_t vecs [3];

  initial begin
    words_t            w;
    logic [AW-1:0]     exp_a;
    logic [DATA_W-1:0] q [$];

    vecs[0] = '{w: {16'd7, 16'd3, 16'd9, 16'd5}, exp_a: 64'h0007_0003_0009_0005,
                gap: 0, fin_dly: 2, dres: 16'd9, hold: 10};
    vecs[1] = '{w: {16'hFFFF, 16'h0001, 16'h5555, 16'hAAAA}, exp_a: 64'hFFFF_0001_5555_AAAA,
                gap: 1, fin_dly: 0, dres: 16'h1234, hold: 0};
    vecs[2] = '{w: {16'h8000, 16'h0000, 16'h0000, 16'h0000}, exp_a: 64'h8000_0000_0000_0000,
                gap: 2, fin_dly: 5, dres: 16'hFFFF, hold: 3};

    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    dp_finished = 1'b0;
    dp_res      = '0;
    res_ready   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_reset_state();

    for (int v = 0; v < 3; v++) begin
      run_job(vecs[v].w, vecs[v].exp_a, vecs[v].gap, vecs[v].fin_dly, vecs[v].dres, vecs[v].hold);
    end

    // Reset after two words, then a fresh job starts at element 0.
    in_valid = 1'b1;
    in_data  = 16'h0011;
    step();
    in_data  = 16'h0022;
    step();
    in_valid = 1'b0;
    check("partial_busy", AW'(busy), 1);
    pulse_reset();
    check_reset_state();
    run_job({16'd4, 16'd3, 16'd2, 16'd1}, 64'h0004_0003_0002_0001, 0, 1, 16'h0042, 1);

    // Reset while waiting on the datapath.
    feed({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D});
    step();
    check("pre_rst_wait_dp_run", AW'(dp_run), 1);
    pulse_reset();
    check_reset_state();

    // Randomized jobs against a queue-based model of accepted words.
    for (int j = 0; j < 20; j++) begin
      int                gap;
      int                fin;
      int                hold;
      logic [DATA_W-1:0] dres;
      q.delete();
      for (int k = 0; k < N; k++) q.push_back(DATA_W'($urandom));
      exp_a = '0;
      for (int k = 0; k < N; k++) begin
        w[k] = q[k];
        exp_a[k*DATA_W +: DATA_W] = q[k];
      end
      gap  = int'($urandom_range(0, 2));
      fin  = int'($urandom_range(0, 5));
      hold = int'($urandom_range(0, 3));
      dres = DATA_W'($urandom);
      run_job(w, exp_a, gap, fin, dres, hold);
    end

`ifdef MAXNET_FEEDER_WATCHDOG_EN
    // No finish: abort after exactly TIMEOUT_CYC WAIT cycles.
    feed({16'd4, 16'd3, 16'd2, 16'd1});
    check("wd_start_load", AW'(dp_load), 1);
    step();
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      check("wd_wait_dp_run", AW'(dp_run), 1);
      check("wd_wait_res_valid", AW'(res_valid), 0);
      step();
    end
    check("wd_abort_res_valid", AW'(res_valid), 1);
    check("wd_abort_timeout", AW'(timeout), 1);
    check("wd_abort_res", AW'(res), 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("wd_abort_ret_ready", AW'(in_ready), 1);

    // Finish on the expiry cycle beats the abort.
    feed({16'd8, 16'd7, 16'd6, 16'd5});
    step();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      check("wd2_wait_dp_run", AW'(dp_run), 1);
      step();
    end
    dp_finished = 1'b1;
    dp_res      = 16'h002A;
    step();
    dp_finished = 1'b0;
    check("wd_race_res_valid", AW'(res_valid), 1);
    check("wd_race_res", AW'(res), 64'h2A);
    check("wd_race_timeout", AW'(timeout), 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
`else
    // Without the watchdog WAIT never aborts on its own.
    feed({16'd4, 16'd3, 16'd2, 16'd1});
    step();
    for (int i = 0; i < 30; i++) begin
      check("nowd_wait_dp_run", AW'(dp_run), 1);
      check("nowd_wait_res_valid", AW'(res_valid), 0);
      check("nowd_timeout", AW'(timeout), 0);
      step();
    end
    dp_finished = 1'b1;
    dp_res      = 16'h002A;
    step();
    dp_finished = 1'b0;
    check("nowd_res", AW'(res), 64'h2A);
    check("nowd_res_timeout", AW'(timeout), 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
`endif
    check("final_in_ready", AW'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
